// File: rtl/deser_fifo_if.sv
// Word handshake between deserializer, receive queue and consumer.
interface deser_fifo_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]       data_in;
  logic                   data_ready_in;
  logic                   ack_out;
  logic                   dequeue_in;
  logic [WIDTH-1:0]       data_out;
  logic                   data_valid_out;
  logic [$clog2(DEPTH):0] len_out;
  logic                   empty_out;
  logic                   full_out;
  logic [7:0]             drop_count_out;

  modport master (
    output data_in, data_ready_in, dequeue_in,
    input  ack_out, data_out, data_valid_out,
    input  len_out, empty_out, full_out,
    input  drop_count_out
  );

  modport slave (
    input  data_in, data_ready_in, dequeue_in,
    output ack_out, data_out, data_valid_out,
    output len_out, empty_out, full_out,
    output drop_count_out
  );
endinterface

// File: rtl/deser_fifo.sv
// Receive word queue behind the bit deserializer.
// DESER_FIFO_DROP_EN: ack and discard words arriving while full.
module deser_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic        clock_100KHz,
  input  logic        reset,
  deser_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    DRAIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [LW-1:0]    len;
  logic             ack;
  logic             dv;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;

  assign full  = (len == LW'(DEPTH));
  assign empty = (len == '0);
  assign enq   = (state == IDLE) &&
                 bus.data_ready_in && !full;
  assign deq   = bus.dequeue_in && !empty;

  always_ff @(posedge clock_100KHz) begin
    if (enq) mem[tail] <= bus.data_in;
  end

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      state <= IDLE;
      ack   <= 1'b0;
      tail  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ack <= 1'b0;
          if (enq) begin
            tail  <= tail + 1'b1;
            ack   <= 1'b1;
            state <= ACK;
          end
`ifdef DESER_FIFO_DROP_EN
          else if (bus.data_ready_in) begin
            ack   <= 1'b1;
            state <= ACK;
          end
`endif
        end
        ACK: begin
          ack   <= 1'b0;
          state <= DRAIN;
        end
        DRAIN: begin
          ack <= 1'b0;
          if (!bus.data_ready_in) state <= IDLE;
        end
        default: begin
          ack   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      head <= '0;
      len  <= '0;
      dv   <= 1'b0;
      dout <= '0;
    end else begin
      dv  <= deq;
      len <= len + {{AW{1'b0}}, enq}
                 - {{AW{1'b0}}, deq};
      if (deq) begin
        dout <= mem[head];
        head <= head + 1'b1;
      end
    end
  end

`ifdef DESER_FIFO_DROP_EN
  logic [7:0] drops;
  logic       drop;

  assign drop = (state == IDLE) &&
                bus.data_ready_in && full;

  always_ff @(posedge clock_100KHz) begin
    if (reset) drops <= '0;
    else if (drop && drops != 8'hFF)
      drops <= drops + 8'd1;
  end

  assign bus.drop_count_out = drops;
`else
  assign bus.drop_count_out = '0;
`endif

  assign bus.ack_out        = ack;
  assign bus.data_out       = dout;
  assign bus.data_valid_out = dv;
  assign bus.len_out        = len;
  assign bus.empty_out      = empty;
  assign bus.full_out       = full;
endmodule

// File: tb/tb_deser_fifo.sv
// Self-checking bench for deser_fifo against a queue model.
// Handshake rules are modelled as accept / ack / wait-for-low phases.
module tb_deser_fifo;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  deser_fifo_if #(.DEPTH(D), .WIDTH(8)) bus ();

  deser_fifo #(.DEPTH(D), .WIDTH(8)) dut (
    .clock_100KHz (clk),
    .reset        (rst),
    .bus          (bus)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0] q [$];
  bit         m_ack;
  bit         m_dv;
  logic [7:0] m_dout;
  logic [7:0] m_drop;
  int         phase;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, o, e);
    end
  endtask

  task automatic model_edge();
    int  n;
    bit  dr;
    bit  take;
    bit  pop;
    dr = bus.data_ready_in;
    if (rst) begin
      q.delete();
      m_ack = 0; m_dv = 0;
      m_dout = 0; m_drop = 0;
      phase = 0;
      return;
    end
    n    = q.size();
    pop  = bus.dequeue_in && n > 0;
    take = 0;
    m_ack = 0;
    if (phase == 0 && dr) begin
      if (n < D) begin
        take = 1; m_ack = 1; phase = 1;
      end
`ifdef DESER_FIFO_DROP_EN
      else begin
        m_ack = 1; phase = 1;
        if (m_drop != 8'hFF) m_drop++;
      end
`endif
    end else if (phase == 1) phase = 2;
    else if (phase == 2 && !dr) phase = 0;
    m_dv = pop;
    if (pop) m_dout = q.pop_front();
    if (take) q.push_back(bus.data_in);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack", 32'(bus.ack_out), 32'(m_ack));
    chk("valid", 32'(bus.data_valid_out), 32'(m_dv));
    chk("data", 32'(bus.data_out), 32'(m_dout));
    chk("len", 32'(bus.len_out), q.size());
    chk("empty", 32'(bus.empty_out),
        32'(q.size() == 0));
    chk("full", 32'(bus.full_out),
        32'(q.size() == D));
    chk("drops", 32'(bus.drop_count_out),
        32'(m_drop));
  endtask

  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    bus.data_ready_in = 1'b1;
    bus.data_in = w;
    do begin
      step();
      n++;
    end while (!m_ack && n < 20);
    if (!m_ack) begin
      compared++;
      mismatched++;
      $error("FAIL send_timeout observed=0 expected=1");
    end
    bus.data_ready_in = 1'b0;
    step();
    step();
  endtask

  task automatic pop(input int k);
    for (int i = 0; i < k; i++) begin
      bus.dequeue_in = 1'b1;
      step();
    end
    bus.dequeue_in = 1'b0;
    step();
  endtask

  initial begin
    bus.data_in = '0;
    bus.data_ready_in = 1'b0;
    bus.dequeue_in = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // single word
    send(8'hA5);
    chk("single_len", 32'(bus.len_out), 1);
    pop(1);
    chk("single_data", 32'(bus.data_out), 32'hA5);

    // fill, backpressure, refill after pop
    for (int i = 1; i <= D; i++) send(8'(i));
    chk("fill_full", 32'(bus.full_out), 1);
    bus.data_ready_in = 1'b1;
    bus.data_in = 8'h09;
    repeat (4) step();
    bus.dequeue_in = 1'b1;
    step();
    bus.dequeue_in = 1'b0;
    repeat (3) step();
    bus.data_ready_in = 1'b0;
    step();
    step();
    pop(D);

    // data_ready held long after ack
    bus.data_ready_in = 1'b1;
    bus.data_in = 8'h3C;
    repeat (6) step();
    bus.data_ready_in = 1'b0;
    step();
    step();
    chk("hold_len", 32'(bus.len_out), 1);
    pop(1);

    // wrap twice
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++)
        send(8'($urandom));
      pop(6);
    end

    // simultaneous push and pop at len 3
    for (int i = 0; i < 3; i++) send(8'(8'h40 + i));
    bus.data_ready_in = 1'b1;
    bus.data_in = 8'h77;
    bus.dequeue_in = 1'b1;
    step();
    bus.dequeue_in = 1'b0;
    chk("simul_len", 32'(bus.len_out), 3);
    bus.data_ready_in = 1'b0;
    step();
    step();
    pop(3);

    // push on empty with pop request
    bus.data_ready_in = 1'b1;
    bus.data_in = 8'h5A;
    bus.dequeue_in = 1'b1;
    step();
    bus.dequeue_in = 1'b0;
    chk("empty_pop_dv", 32'(bus.data_valid_out), 0);

    // reset while acking
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.data_ready_in = 1'b0;
    chk("rst_ack", 32'(bus.ack_out), 0);
    step();

`ifdef DESER_FIFO_DROP_EN
    for (int i = 0; i < D; i++) send(8'(8'h80 + i));
    for (int i = 0; i < 3; i++) send(8'hEE);
    chk("drop_cnt", 32'(bus.drop_count_out), 3);
    pop(D);
`endif

    // randomized deserializer / consumer traffic
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(199) == 0);
      if (m_ack) bus.data_ready_in = 1'b0;
      else if (!bus.data_ready_in &&
               $urandom_range(2) == 0) begin
        bus.data_ready_in = 1'b1;
        bus.data_in = 8'($urandom);
      end
      bus.dequeue_in = ($urandom_range(4) < 2);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
